spi_master_multi: RTL and testbench

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

---
 rtl/spi_master_multi.sv | 142 ++++++++++++++
 tb/tb_spi_master_multi.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// SPI master: one DATA_WIDTH-bit word per transfer, per-transfer CPOL/CPHA,
// spi_clk half-period of CLK_DIV clk cycles, decoded active-low chip selects.
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int CS_COUNT   = 4,
  parameter int CLK_DIV    = 4,
  parameter bit MSB_FIRST  = 1'b1,
  localparam int CSW = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [CSW-1:0]        cs_sel,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  miso,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  spi_clk,
  output logic                  mosi,
  output logic [CS_COUNT-1:0]   cs_n
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t                state, state_next;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  cpha_q;
  logic [CSW-1:0]        sel_q;
  logic                  tick;
  logic                  last_edge;
  logic                  sample_edge;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                     input logic b);
    return MSB_FIRST ? {v[DATA_WIDTH-2:0], b} : {b, v[DATA_WIDTH-1:1]};
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign last_edge = (edge_cnt == EDGE_LAST);
  // Toggles are numbered from 1, so the upcoming one is leading when edge_cnt is even.
  assign sample_edge = (edge_cnt[0] == cpha_q);

  assign ready = (state == IDLE);
  assign busy  = (state == SETUP) || (state == XFER) || (state == HOLD);
  assign done  = (state == DONE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)             state_next = SETUP;
      SETUP:   if (tick)              state_next = XFER;
      XFER:    if (tick && last_edge) state_next = HOLD;
      HOLD:    if (tick)              state_next = DONE;
      DONE:                           state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // An out-of-range latched index matches no line, so every select stays high.
  always_comb begin
    cs_n = '1;
    for (int i = 0; i < CS_COUNT; i++) begin
      if (busy && (sel_q == CSW'(i))) cs_n[i] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      spi_clk  <= 1'b0;
      mosi     <= 1'b0;
      rx_data  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpha_q   <= 1'b0;
      sel_q    <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          spi_clk  <= cpol;
          mosi     <= 1'b0;
          div_cnt  <= '0;
          edge_cnt <= '0;
          if (start) begin
            cpha_q <= cpha;
            sel_q  <= cs_sel;
            rx_sr  <= '0;
            // With cpha=0 the first bit goes out now, so the register already holds the next one.
            tx_sr  <= cpha ? tx_data : shift_out(tx_data);
            mosi   <= cpha ? 1'b0 : first_bit(tx_data);
          end
        end
        SETUP: div_cnt <= tick ? '0 : div_cnt + 1'b1;
        XFER: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            spi_clk  <= ~spi_clk;
            edge_cnt <= edge_cnt + 1'b1;
            if (sample_edge) begin
              rx_sr <= shift_in(rx_sr, miso);
            end else if (!last_edge) begin
              mosi  <= first_bit(tx_sr);
              tx_sr <= shift_out(tx_sr);
            end
          end
        end
        HOLD: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) rx_data <= rx_sr;
        end
        DONE:    mosi <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench: two configurations of spi_master_multi driven through a
// shared SPI slave model, table-driven vectors, random transfers and hand-written corner cases.
module tb_spi_master_multi;

  logic       clk = 1'b0;
  logic       reset, start, cpol, cpha, sel_b, loop_en, slv_miso;
  logic [1:0] cs_sel;
  logic [7:0] tx_data;

  logic       a_ready, a_busy, a_done, a_spi_clk, a_mosi;
  logic [7:0] a_rx;
  logic [3:0] a_cs_n;
  logic       b_ready, b_busy, b_done, b_spi_clk, b_mosi;
  logic [7:0] b_rx;
  logic [2:0] b_cs_n;

  logic       m_ready, m_busy, m_done, m_spi_clk, m_mosi;
  logic [7:0] m_rx;
  logic [3:0] m_cs_n;
  logic       a_start, b_start, miso_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign a_start   = start & ~sel_b;
  assign b_start   = start & sel_b;
  assign m_ready   = sel_b ? b_ready   : a_ready;
  assign m_busy    = sel_b ? b_busy    : a_busy;
  assign m_done    = sel_b ? b_done    : a_done;
  assign m_spi_clk = sel_b ? b_spi_clk : a_spi_clk;
  assign m_mosi    = sel_b ? b_mosi    : a_mosi;
  assign m_rx      = sel_b ? b_rx      : a_rx;
  assign m_cs_n    = sel_b ? {1'b1, b_cs_n} : a_cs_n;
  assign miso_w    = loop_en ? m_mosi : slv_miso;

  // Default configuration: 8 bits, 4 selects, divide by 4, MSB first.
  spi_master_multi dut_a (
    .clk(clk), .reset(reset), .start(a_start), .cpol(cpol), .cpha(cpha),
    .cs_sel(cs_sel), .tx_data(tx_data), .miso(miso_w),
    .ready(a_ready), .busy(a_busy), .done(a_done), .rx_data(a_rx),
    .spi_clk(a_spi_clk), .mosi(a_mosi), .cs_n(a_cs_n)
  );

  // Three selects (so index 3 is out of range), divide by 1, LSB first.
  spi_master_multi #(.DATA_WIDTH(8), .CS_COUNT(3), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .cpol(cpol), .cpha(cpha),
    .cs_sel(cs_sel), .tx_data(tx_data), .miso(miso_w),
    .ready(b_ready), .busy(b_busy), .done(b_done), .rx_data(b_rx),
    .spi_clk(b_spi_clk), .mosi(b_mosi), .cs_n(b_cs_n)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // SPI slave model: watches spi_clk while the master is busy, samples mosi on its
  // sampling edge and presents its own word on miso, bit order following the selected DUT.
  logic       s_cpol, s_cpha, s_prev, s_lead;
  logic [7:0] s_word, s_got;
  int         s_idx;

  function automatic int pos(input int i);
    return sel_b ? i : 7 - i;
  endfunction

  always @(negedge clk) begin
    if (!m_busy) begin
      s_idx = 0;
      if (!s_cpha) slv_miso = s_word[pos(0)];
    end else if (m_spi_clk !== s_prev) begin
      s_lead = (m_spi_clk !== s_cpol);
      if (!s_cpha) begin
        if (s_lead) s_got[pos(s_idx)] = m_mosi;
        else begin
          s_idx++;
          if (s_idx < 8) slv_miso = s_word[pos(s_idx)];
        end
      end else begin
        if (s_lead) slv_miso = s_word[pos(s_idx)];
        else begin
          s_got[pos(s_idx)] = m_mosi;
          s_idx++;
        end
      end
    end
    s_prev = m_spi_clk;
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (m_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s.ready_timeout: got=%0b expected=1", name, m_ready);
    end
  endtask

  // One complete transfer; after acceptance the inputs are inverted to prove they were latched.
  task automatic xfer(input string name, input bit on_b, input bit pol, input bit pha,
                      input logic [1:0] sel, input logic [7:0] tx, input bit loop,
                      input logic [7:0] word, input bit poke,
                      input logic [7:0] exp_rx, input logic [3:0] exp_cs);
    int         lat, n_done, done_at, toggles;
    bit         cs_bad, rx_moved, prev_clk;
    logic [7:0] rx_before, rx_at_done;
    logic [3:0] cs_at_done;
    lat        = on_b ? 18 : 72;
    rx_at_done = 8'hxx;
    cs_at_done = 4'hx;
    @(negedge clk);
    sel_b = on_b; loop_en = loop; s_word = word; s_cpol = pol; s_cpha = pha; s_got = 8'h00;
    cpol = pol; cpha = pha; cs_sel = sel; tx_data = tx;
    wait_ready(name);
    @(negedge clk);
    check($sformatf("%s.idle_spi_clk", name), 32'(m_spi_clk), 32'(pol));
    rx_before = m_rx;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cpol = ~pol; cpha = ~pha; cs_sel = ~sel; tx_data = ~tx;
    if (!pha) check($sformatf("%s.first_mosi", name), 32'(m_mosi), 32'(on_b ? tx[0] : tx[7]));
    n_done = 0; done_at = -1; toggles = 0; rx_moved = 1'b0;
    cs_bad   = (m_cs_n !== exp_cs);
    prev_clk = m_spi_clk;
    for (int cyc = 1; cyc <= lat + 3; cyc++) begin
      @(posedge clk); #1;
      if (poke && cyc == 10) begin start = 1'b1; tx_data = 8'hFF; end
      if (poke && cyc == 11) start = 1'b0;
      if (m_done === 1'b1) begin
        n_done++;
        done_at    = cyc;
        rx_at_done = m_rx;
      end else if (cyc < lat && m_rx !== rx_before) rx_moved = 1'b1;
      if (cyc < lat && m_cs_n !== exp_cs) cs_bad = 1'b1;
      if (cyc == lat) cs_at_done = m_cs_n;
      if (cyc <= lat && m_spi_clk !== prev_clk) toggles++;
      prev_clk = m_spi_clk;
    end
    check($sformatf("%s.done_count", name), 32'(n_done), 32'd1);
    check($sformatf("%s.done_cycle", name), 32'(done_at), 32'(lat));
    check($sformatf("%s.rx_data", name), 32'(rx_at_done), 32'(exp_rx));
    check($sformatf("%s.slave_rx", name), 32'(s_got), 32'(tx));
    check($sformatf("%s.cs_n_busy_ok", name), 32'(cs_bad), 32'd0);
    check($sformatf("%s.cs_n_at_done", name), 32'(cs_at_done), 32'hF);
    check($sformatf("%s.spi_clk_toggles", name), 32'(toggles), 32'd16);
    check($sformatf("%s.rx_held", name), 32'(rx_moved), 32'd0);
  endtask

  typedef struct {
    bit         on_b, pol, pha;
    logic [1:0] sel;
    logic [7:0] tx;
    bit         loop;
    logic [7:0] word;
    bit         poke;
    logic [7:0] exp_rx;
    logic [3:0] exp_cs;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n_done;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'hB7, 1'b1, 8'h00, 1'b0, 8'hB7, 4'b1110};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 2'd1, 8'h5A, 1'b0, 8'hAD, 1'b0, 8'hAD, 4'b1101};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'hC3, 1'b0, 8'h96, 1'b0, 8'h96, 4'b1011};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h3C, 1'b0, 8'h81, 1'b1, 8'h81, 4'b0111};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h01, 1'b1, 8'h00, 1'b0, 8'h01, 4'b1110};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 2'd3, 8'hA5, 1'b0, 8'h4E, 1'b0, 8'h4E, 4'b1111};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'h6B, 1'b0, 8'hD2, 1'b0, 8'hD2, 4'b1011};

    reset = 1'b1; start = 1'b0; cpol = 1'b1; cpha = 1'b0; cs_sel = 2'd0; tx_data = 8'h00;
    sel_b = 1'b0; loop_en = 1'b0; slv_miso = 1'b0;
    s_word = 8'h00; s_got = 8'h00; s_cpol = 1'b0; s_cpha = 1'b0; s_prev = 1'b0; s_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(a_ready), 32'd1);
    check("rst.busy", 32'(a_busy), 32'd0);
    check("rst.done", 32'(a_done), 32'd0);
    check("rst.rx_data", 32'(a_rx), 32'd0);
    check("rst.spi_clk", 32'(a_spi_clk), 32'd0);
    check("rst.mosi", 32'(a_mosi), 32'd0);
    check("rst.cs_n", 32'(a_cs_n), 32'hF);
    check("rst.cs_n_b", 32'(b_cs_n), 32'h7);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle.spi_clk_follows_cpol", 32'(a_spi_clk), 32'd1);

    // Reset at cycle 30 of a transfer: aborts at once, no done, rx_data stays at its cleared value.
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0; tx_data = 8'h3C; loop_en = 1'b1;
    s_cpol = 1'b0; s_cpha = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("abort.cs_n_before", 32'(a_cs_n), 32'hE);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort.cs_n", 32'(a_cs_n), 32'hF);
    check("abort.ready", 32'(a_ready), 32'd1);
    check("abort.rx_data", 32'(a_rx), 32'd0);
    n_done = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_done === 1'b1) n_done++;
      @(posedge clk); #1;
    end
    check("abort.no_done", 32'(n_done), 32'd0);

    for (int i = 0; i < 7; i++) begin
      xfer($sformatf("vec%0d", i), vecs[i].on_b, vecs[i].pol, vecs[i].pha, vecs[i].sel,
           vecs[i].tx, vecs[i].loop, vecs[i].word, vecs[i].poke, vecs[i].exp_rx, vecs[i].exp_cs);
    end

    // Random transfers: the slave word must come back as rx_data, and only the
    // addressed select (if it exists on that DUT) may go low.
    for (int i = 0; i < 10; i++) begin
      bit         on_b, pol, pha;
      logic [1:0] sel;
      logic [7:0] tx, word;
      logic [3:0] ec;
      on_b = 1'($urandom_range(0, 1));
      pol  = 1'($urandom_range(0, 1));
      pha  = 1'($urandom_range(0, 1));
      sel  = 2'($urandom_range(0, 3));
      tx   = 8'($urandom);
      word = 8'($urandom);
      ec   = 4'hF;
      if (int'(sel) < (on_b ? 3 : 4)) ec[sel] = 1'b0;
      xfer($sformatf("rand%0d", i), on_b, pol, pha, sel, tx, 1'b0, word, 1'b0, word, ec);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
